// File: rtl/sobel_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_ctrl
// Purpose  : Line-buffer controller and read sequencer for a 3x3 Sobel
//            datapath. A raster pixel stream is written into four rotating
//            line buffers. Once three full lines are held, one 3x3 window
//            is issued per enabled cycle. An interrupt pulse tells the
//            upstream DMA that a line has been consumed.
// Ports    : i_clk              - rising-edge clock
//            i_rstn             - asynchronous active-low reset
//            i_pixel_data       - incoming 8-bit pixel
//            i_pixel_data_valid - write strobe for i_pixel_data
//            i_rd_en            - downstream enable, low stalls reads
//            o_pixel_data       - 3x3 window, byte k at [k*8+:8]
//            o_pixel_data_valid - o_pixel_data valid this cycle
//            o_intr             - one-cycle pulse after a line is consumed
//            o_overflow         - sticky, set when a write was dropped
// Options  : SOBEL_EDGE_REPLICATE_EN - when defined, columns past the end
//            of a line replicate the last pixel; otherwise they read 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_line_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int ADDR_W    = 9,
  parameter int CNT_W     = 12
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic        i_rd_en,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr,
  output logic        o_overflow
);

  localparam logic [CNT_W-1:0]  c_full     = CNT_W'(4 * IMG_WIDTH);
  localparam logic [CNT_W-1:0]  c_three    = CNT_W'(3 * IMG_WIDTH);
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W:0]   c_last_col = (ADDR_W + 1)'(IMG_WIDTH - 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_read = 1'b1;

  // Four line buffers, flattened; entry {line, column}. Not reset.
  logic [7:0] line_mem_q [0:(4 << ADDR_W) - 1];

  logic [0:0]        state_q,  state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              intr_pend_q;
  logic [71:0]       data_q;
  logic              valid_q;
  logic              intr_q;
  logic              overflow_q;

  logic              w_accept;
  logic              w_drop;
  logic              w_rd;
  logic              w_rd_last;
  logic [71:0]       w_window;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept  = i_pixel_data_valid && (count_q < c_full);
    w_drop    = i_pixel_data_valid && (count_q >= c_full);
    w_rd      = (state_q == c_st_read) && i_rd_en;
    w_rd_last = w_rd && (rd_ptr_q == c_last);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_sel_d = wr_sel_q;
    rd_ptr_d = rd_ptr_q;
    rd_sel_d = rd_sel_q;
    state_d  = state_q;
    count_d  = count_q;

    if (w_accept) begin
      if (wr_ptr_q == c_last) begin
        wr_ptr_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end

    // A simultaneous write and read leave the occupancy unchanged.
    case ({w_accept, w_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      c_st_idle: begin
        if (count_q >= c_three) begin
          state_d  = c_st_read;
          rd_ptr_d = '0;
        end
      end
      c_st_read: begin
        if (w_rd_last) begin
          state_d  = c_st_idle;
          rd_ptr_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
        end else if (w_rd) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Window assembly: row r is line (rd_sel + r) mod 4, column rd_ptr + c.
  // The column sum carries one extra bit so that running off the end of the
  // line is detected rather than wrapping into the next buffer.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [ADDR_W:0]   w_col;
      logic              w_oob;
      logic [1:0]        w_row;
      logic [ADDR_W-1:0] w_addr;

      assign w_col = {1'b0, rd_ptr_q} + (ADDR_W + 1)'(c);
      assign w_oob = (w_col > c_last_col);
      assign w_row = rd_sel_q + 2'(r);
`ifdef SOBEL_EDGE_REPLICATE_EN
      assign w_addr = w_oob ? c_last : w_col[ADDR_W-1:0];
      assign w_window[(r*3+c)*8 +: 8] = line_mem_q[{w_row, w_addr}];
`else
      assign w_addr = w_col[ADDR_W-1:0];
      assign w_window[(r*3+c)*8 +: 8] = w_oob ? 8'h00 : line_mem_q[{w_row, w_addr}];
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer storage
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      line_mem_q[{wr_sel_q, wr_ptr_q}] <= i_pixel_data;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= c_st_idle;
      wr_ptr_q    <= '0;
      wr_sel_q    <= '0;
      rd_ptr_q    <= '0;
      rd_sel_q    <= '0;
      count_q     <= '0;
      intr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      intr_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_sel_q    <= wr_sel_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_sel_q    <= rd_sel_d;
      count_q     <= count_d;
      valid_q     <= w_rd;
      if (w_rd) begin
        data_q <= w_window;
      end
      // Two stages so the interrupt lands one cycle after the last window.
      intr_pend_q <= w_rd_last;
      intr_q      <= intr_pend_q;
      overflow_q  <= overflow_q | w_drop;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;
  assign o_overflow         = overflow_q;

endmodule
`default_nettype wire
